// File: rtl/lsu_mem_port_if.sv
// Bundles the pipeline request/response handshakes and the data-memory bus of the LSU.
// The master modport is the LSU's view of these signals; the slave modport is the view of the pipeline and memory.
interface lsu_mem_port_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_store;
    logic [2:0]            req_funct3;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    logic [1:0]            mem_we;
    logic [DATA_WIDTH-1:0] mem_a;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic [DATA_WIDTH-1:0] mem_rd;

    modport master (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
    );

    modport slave (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store unit initiator: one request at a time, fixed-latency memory read,
// RV32I sub-word store enables and load sign/zero extension, single registered response.
module lsu_mem_port #(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 0
) (
    input  logic              clk,
    input  logic              rst,
    lsu_mem_port_if.master    bus
);
    localparam int CW = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;

    typedef enum logic [1:0] {IDLE, STORE, LOAD, RESP} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [2:0]            r_funct3;
    logic                  r_req_ready;
    logic                  r_resp_valid;
    logic                  r_resp_err;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic [1:0]            r_mem_we;
    logic [DATA_WIDTH-1:0] r_mem_a;
    logic [DATA_WIDTH-1:0] r_mem_wd;

    function automatic logic f_legal(input logic store, input logic [2:0] f3);
        if (store) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    function automatic logic [1:0] f_we(input logic [2:0] f3);
        case (f3)
            3'b000:  return 2'b11;
            3'b001:  return 2'b10;
            3'b010:  return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_extend(input logic [2:0] f3,
                                                       input logic [DATA_WIDTH-1:0] rd);
        case (f3)
            3'b000:  return {{(DATA_WIDTH-8){rd[7]}}, rd[7:0]};
            3'b001:  return {{(DATA_WIDTH-16){rd[15]}}, rd[15:0]};
            3'b100:  return {{(DATA_WIDTH-8){1'b0}}, rd[7:0]};
            3'b101:  return {{(DATA_WIDTH-16){1'b0}}, rd[15:0]};
            default: return rd;
        endcase
    endfunction

    // req_ready stays low through reset and rises on the first clock after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_funct3     <= '0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_we     <= 2'b00;
            r_mem_a      <= '0;
            r_mem_wd     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (bus.req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_funct3    <= bus.req_funct3;
                        r_mem_a     <= bus.req_addr;
                        r_mem_wd    <= bus.req_wdata;
                        if (!f_legal(bus.req_store, bus.req_funct3)) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else if (bus.req_store) begin
                            r_state  <= STORE;
                            r_mem_we <= f_we(bus.req_funct3);
                        end else begin
                            r_state <= LOAD;
                            r_cnt   <= '0;
                        end
                    end
                end
                STORE: begin
                    r_mem_we     <= 2'b00;
                    r_state      <= RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                end
                LOAD: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(MEM_LATENCY)) begin
                        r_resp_rdata <= f_extend(r_funct3, bus.mem_rd);
                        r_resp_err   <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= '0;
                        r_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_a      = r_mem_a;
    assign bus.mem_wd     = r_mem_wd;
endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with three instances (MEM_LATENCY 0, 2, 3);
// expected responses go to a scoreboard queue when a request is driven and are popped on handshake.
module tb_lsu_mem_port;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]        req_valid_a  = '0;
    logic [2:0]        req_store_a  = '0;
    logic [2:0][2:0]   req_funct3_a = '0;
    logic [2:0][31:0]  req_addr_a   = '0;
    logic [2:0][31:0]  req_wdata_a  = '0;
    logic [2:0]        resp_ready_a = '0;
    logic [2:0][31:0]  mem_rd_a     = '0;
    wire  [2:0]        req_ready_a;
    wire  [2:0]        resp_valid_a;
    wire  [2:0]        resp_err_a;
    wire  [2:0][31:0]  resp_rdata_a;
    wire  [2:0][1:0]   mem_we_a;
    wire  [2:0][31:0]  mem_a_a;
    wire  [2:0][31:0]  mem_wd_a;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 0 : ((gi == 1) ? 2 : 3);
        lsu_mem_port_if #(.DATA_WIDTH(32)) bus_i ();
        assign bus_i.req_valid  = req_valid_a[gi];
        assign bus_i.req_store  = req_store_a[gi];
        assign bus_i.req_funct3 = req_funct3_a[gi];
        assign bus_i.req_addr   = req_addr_a[gi];
        assign bus_i.req_wdata  = req_wdata_a[gi];
        assign bus_i.resp_ready = resp_ready_a[gi];
        assign bus_i.mem_rd     = mem_rd_a[gi];
        assign req_ready_a[gi]  = bus_i.req_ready;
        assign resp_valid_a[gi] = bus_i.resp_valid;
        assign resp_err_a[gi]   = bus_i.resp_err;
        assign resp_rdata_a[gi] = bus_i.resp_rdata;
        assign mem_we_a[gi]     = bus_i.mem_we;
        assign mem_a_a[gi]      = bus_i.mem_a;
        assign mem_wd_a[gi]     = bus_i.mem_wd;
        lsu_mem_port #(.DATA_WIDTH(32), .MEM_LATENCY(LAT)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus_i.master)
        );
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full transaction on instance k; rd_sample is presented in the cycle the unit samples mem_rd.
    task automatic do_req(input int k, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rd_early, input logic [31:0] rd_sample,
                          input int bp, input string tag);
        int          lat_cfg;
        int          exp_lat;
        int          n;
        int          we_cnt;
        logic        legal;
        logic [1:0]  we_exp;
        logic [31:0] held_rdata;
        logic        held_err;
        exp_t        e;
        exp_t        got;
        lat_cfg = (k == 0) ? 0 : ((k == 1) ? 2 : 3);
        legal   = st ? (f3 inside {3'b000, 3'b001, 3'b010})
                     : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        we_exp  = (st && legal) ? ((f3 == 3'b000) ? 2'b11 : ((f3 == 3'b001) ? 2'b10 : 2'b01)) : 2'b00;
        exp_lat = !legal ? 1 : (st ? 2 : 2 + lat_cfg);
        e.err   = !legal;
        e.rdata = 32'h0;
        if (legal && !st) begin
            case (f3)
                3'b000:  e.rdata = {{24{rd_sample[7]}}, rd_sample[7:0]};
                3'b001:  e.rdata = {{16{rd_sample[15]}}, rd_sample[15:0]};
                3'b100:  e.rdata = {24'h0, rd_sample[7:0]};
                3'b101:  e.rdata = {16'h0, rd_sample[15:0]};
                default: e.rdata = rd_sample;
            endcase
        end
        exp_q.push_back(e);

        chk({tag, "_req_ready_idle"}, {31'h0, req_ready_a[k]}, 32'h1);
        req_valid_a[k]  = 1'b1;
        req_store_a[k]  = st;
        req_funct3_a[k] = f3;
        req_addr_a[k]   = addr;
        req_wdata_a[k]  = wdata;
        mem_rd_a[k]     = rd_early;
        step();
        req_valid_a[k] = 1'b0;

        n = 1;
        we_cnt = 0;
        while (!resp_valid_a[k] && n <= 20) begin
            chk({tag, "_req_ready_busy"}, {31'h0, req_ready_a[k]}, 32'h0);
            chk({tag, "_mem_we"}, {30'h0, mem_we_a[k]}, {30'h0, (n == 1) ? we_exp : 2'b00});
            if (mem_we_a[k] != 2'b00) we_cnt++;
            if (n == 1 && we_exp != 2'b00) begin
                chk({tag, "_mem_a"}, mem_a_a[k], addr);
                chk({tag, "_mem_wd"}, mem_wd_a[k], wdata);
            end
            if (!st && legal && n == 1 + lat_cfg) mem_rd_a[k] = rd_sample;
            if (!st && legal) chk({tag, "_mem_a_load"}, mem_a_a[k], addr);
            step();
            n++;
        end
        chk({tag, "_resp_latency"}, n, exp_lat);
        chk({tag, "_we_count"}, we_cnt, (we_exp != 2'b00) ? 1 : 0);

        held_rdata = resp_rdata_a[k];
        held_err   = resp_err_a[k];
        for (int i = 0; i < bp; i++) begin
            chk({tag, "_bp_valid"}, {31'h0, resp_valid_a[k]}, 32'h1);
            chk({tag, "_bp_rdata"}, resp_rdata_a[k], held_rdata);
            chk({tag, "_bp_err"}, {31'h0, resp_err_a[k]}, {31'h0, held_err});
            chk({tag, "_bp_req_ready"}, {31'h0, req_ready_a[k]}, 32'h0);
            chk({tag, "_bp_mem_we"}, {30'h0, mem_we_a[k]}, 32'h0);
            step();
        end

        resp_ready_a[k] = 1'b1;
        got = exp_q.pop_front();
        chk({tag, "_resp_valid"}, {31'h0, resp_valid_a[k]}, 32'h1);
        chk({tag, "_rdata"}, resp_rdata_a[k], got.rdata);
        chk({tag, "_err"}, {31'h0, resp_err_a[k]}, {31'h0, got.err});
        step();
        resp_ready_a[k] = 1'b0;
        chk({tag, "_resp_drop"}, {31'h0, resp_valid_a[k]}, 32'h0);
        chk({tag, "_req_ready_after"}, {31'h0, req_ready_a[k]}, 32'h1);
        $display("txn %s inst=%0d store=%0b f3=%03b latency=%0d rdata=0x%08h err=%0b",
                 tag, k, st, f3, n, got.rdata, got.err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        step();
        step();
        chk("rst_req_ready", {31'h0, req_ready_a[0]}, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid_a[0]}, 32'h0);
        chk("rst_mem_we", {30'h0, mem_we_a[0]}, 32'h0);
        chk("rst_resp_rdata", resp_rdata_a[0], 32'h0);
        chk("rst_mem_a", mem_a_a[0], 32'h0);
        rst = 1'b0;
        step();
        for (int k = 0; k < 3; k++) chk("post_rst_req_ready", {31'h0, req_ready_a[k]}, 32'h1);

        do_req(0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 32'h0, 0, "SW");
        do_req(0, 1'b1, 3'b001, 32'h208, 32'hCAFE1234, 32'h0, 32'h0, 0, "SH");
        do_req(0, 1'b0, 3'b000, 32'h300, 32'h0, 32'h0, 32'h000000F0, 0, "LB");
        do_req(0, 1'b0, 3'b100, 32'h300, 32'h0, 32'h0, 32'h000000F0, 0, "LBU");
        do_req(0, 1'b0, 3'b001, 32'h304, 32'h0, 32'h0, 32'h00018001, 0, "LH");
        do_req(0, 1'b0, 3'b101, 32'h304, 32'h0, 32'h0, 32'h00018001, 0, "LHU");
        do_req(0, 1'b0, 3'b010, 32'h308, 32'h0, 32'h0, 32'h89ABCDEF, 0, "LW0");
        do_req(0, 1'b1, 3'b011, 32'h400, 32'h55555555, 32'h0, 32'h0, 0, "ST_ILL011");
        do_req(0, 1'b0, 3'b110, 32'h404, 32'h0, 32'h0, 32'h12345678, 0, "LD_ILL110");
        do_req(0, 1'b1, 3'b100, 32'h408, 32'h0, 32'h0, 32'h0, 0, "ST_ILL100");
        do_req(1, 1'b0, 3'b010, 32'h10000, 32'h0, 32'h11111111, 32'h22222222, 0, "LW_LAT2");
        do_req(0, 1'b1, 3'b000, 32'h20, 32'h12345678, 32'h0, 32'h0, 5, "SB_BP");
        do_req(1, 1'b0, 3'b000, 32'h24, 32'h0, 32'h0, 32'h00000080, 2, "LB_LAT2_BP");

        // Reset during a LOAD on the latency-3 instance, with a request held during reset.
        req_valid_a[2]  = 1'b1;
        req_store_a[2]  = 1'b0;
        req_funct3_a[2] = 3'b010;
        req_addr_a[2]   = 32'h40;
        mem_rd_a[2]     = 32'hAAAAAAAA;
        step();
        req_valid_a[2] = 1'b0;
        step();
        rst             = 1'b1;
        req_valid_a[2]  = 1'b1;
        req_store_a[2]  = 1'b1;
        req_funct3_a[2] = 3'b010;
        req_wdata_a[2]  = 32'h77777777;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rstmid_resp_valid", {31'h0, resp_valid_a[2]}, 32'h0);
            chk("rstmid_mem_we", {30'h0, mem_we_a[2]}, 32'h0);
            chk("rstmid_req_ready", {31'h0, req_ready_a[2]}, 32'h0);
        end
        rst            = 1'b0;
        req_valid_a[2] = 1'b0;
        step();
        chk("rstrel_req_ready", {31'h0, req_ready_a[2]}, 32'h1);
        for (int i = 0; i < 6; i++) begin
            chk("rstrel_no_resp", {31'h0, resp_valid_a[2]}, 32'h0);
            chk("rstrel_mem_we", {30'h0, mem_we_a[2]}, 32'h0);
            step();
        end
        $display("txn RST_MID inst=2 load abandoned");

        do_req(2, 1'b0, 3'b010, 32'h44, 32'h0, 32'h0, 32'hCAFEF00D, 0, "LW_LAT3");
        do_req(2, 1'b1, 3'b010, 32'h48, 32'h0BADF00D, 32'h0, 32'h0, 0, "SW_LAT3");

        chk("scoreboard_empty", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit: the initiator side of the data-memory port.
- Accepts one load or store at a time from the execute stage over a valid/ready handshake.
- Translates RV32I funct3 into the 2-bit memory write-enable code, drives address and write data, samples read data after a fixed latency, and sign- or zero-extends load results.
- Returns a single response to the pipeline over a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, width of address, write data, read data and response data.
- MEM_LATENCY, 0, extra cycles between driving mem_a and sampling mem_rd (0 = combinational read).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- req_valid  input  1  pipeline request valid
- req_ready  output  1  unit can accept a request
- req_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3 of the load/store
- req_addr  input  DATA_WIDTH  effective address, passed to memory unmodified
- req_wdata  input  DATA_WIDTH  store data
- resp_valid  output  1  response valid
- resp_ready  input  1  pipeline accepts response
- resp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors
- resp_err  output  1  illegal funct3; no memory access was made
- mem_we  output  2  00 none, 01 word, 10 half (bits 15:0), 11 byte (bits 7:0)
- mem_a  output  DATA_WIDTH  memory address
- mem_wd  output  DATA_WIDTH  memory write data
- mem_rd  input  DATA_WIDTH  memory read data

Behaviour:
- Reset: state IDLE, latency counter 0; all outputs 0 except req_ready. req_ready=0 while rst=1 and 1 in the first cycle after.
- State IDLE:
  - req_ready=1.
  - On req_valid&req_ready, capture store, funct3, addr and wdata into registers.
  - Illegal funct3 → RESP with err=1. Load-legal: 000, 001, 010, 100, 101. Store-legal: 000, 001, 010.
  - Legal store → STORE. Legal load → LOAD, counter=0.
- State STORE (exactly 1 cycle):
  - mem_we = 11/10/01 for funct3 000/001/010.
  - mem_a = captured addr; mem_wd = full captured wdata (memory selects the low bits).
  - Next state RESP.
- State LOAD:
  - mem_we=00; mem_a held at captured addr.
  - Counter increments each cycle.
  - In the cycle where counter==MEM_LATENCY, register the extended mem_rd into resp_rdata; next state RESP.
  - Total LOAD duration = MEM_LATENCY+1 cycles.
- Load extension:
  - 000 sign-extend rd[7:0]; 001 sign-extend rd[15:0]; 010 rd unchanged.
  - 100 zero-extend rd[7:0]; 101 zero-extend rd[15:0].
- State RESP:
  - resp_valid=1; resp_rdata and resp_err held stable until resp_valid&resp_ready.
  - On handshake → IDLE; resp_valid drops the next cycle.
  - No new request is accepted during RESP: req_ready=0 in every non-IDLE state.
- mem_we is 00 in every cycle except the single STORE cycle; a store writes exactly once per request.
- Latency from the acceptance cycle T:
  - Store: mem_we active at T+1, resp_valid at T+2.
  - Load: resp_valid at T+2+MEM_LATENCY.
  - Error: resp_valid at T+1.
- Back-to-back requests: the minimum request spacing is 3 cycles for a store with resp_ready held high.
- Reset mid-operation: the transaction is abandoned with no response. mem_we=00 from the cycle after rst is sampled. The registered mem_we cannot persist into reset.
- Simultaneous req_valid and rst: the request is ignored.
- Address and data pass through with no wrap or alignment checks. Sub-word access always uses the low bits of the addressed word.

Test Plan:
- SW (funct3 010, addr 0x104, wdata 0xDEADBEEF) → mem_we=01, mem_a=0x104, mem_wd=0xDEADBEEF for exactly one cycle at T+1; resp_valid at T+2 with rdata=0, err=0.
- LB with mem_rd=0x000000F0, MEM_LATENCY=0 → resp_rdata=0xFFFFFFF0. Same with LBU → 0x000000F0. LH with mem_rd=0x00018001 → 0xFFFF8001; LHU → 0x00008001.
- MEM_LATENCY=2, LW addr 0x10000 with mem_rd changing from 0x11111111 to 0x22222222 in the sample cycle (counter==2) → resp_rdata=0x22222222, resp_valid at T+4.
- Illegal funct3: store 011 and load 110 → resp_err=1, resp_rdata=0, mem_we stays 00 throughout, resp_valid at T+1.
- Backpressure: SB with resp_ready low for 5 cycles → resp_valid and data held stable, req_ready=0, mem_we=11 only once; the next request is accepted only after the handshake.
- Assert rst during LOAD (MEM_LATENCY=3) → no resp_valid, mem_we=00. req_ready=0 while rst=1 and 1 the cycle after release; a subsequent LW completes normally.
